// File: rtl/alu_seq_pkg.sv
// Shared constants, opcodes and FSM state encoding for the sequential ALU.
// The ALU_SEQ_FAST_MUL_EN build option is handled in alu_seq.sv.
package alu_seq_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int OPRN_WIDTH = 6;
   localparam int STEP_WIDTH = $clog2(DATA_WIDTH + 1);

   localparam logic [OPRN_WIDTH-1:0] OP_ADD = 6'h01;
   localparam logic [OPRN_WIDTH-1:0] OP_SUB = 6'h02;
   localparam logic [OPRN_WIDTH-1:0] OP_MUL = 6'h03;
   localparam logic [OPRN_WIDTH-1:0] OP_AND = 6'h04;
   localparam logic [OPRN_WIDTH-1:0] OP_OR  = 6'h05;
   localparam logic [OPRN_WIDTH-1:0] OP_NOR = 6'h06;
   localparam logic [OPRN_WIDTH-1:0] OP_SLT = 6'h07;
   localparam logic [OPRN_WIDTH-1:0] OP_SHL = 6'h08;
   localparam logic [OPRN_WIDTH-1:0] OP_SHR = 6'h09;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per step, LSB of the
// multiplier first. Load already applies the first step.
module alu_seq_mul
   import alu_seq_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic                  step,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] product,
   output logic                  done
);

   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [DATA_WIDTH-1:0] prod;
   logic [STEP_WIDTH-1:0] remaining;

   // Folding bit 0 into the load lets the owner finish on its last step edge
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mcand     <= '0;
         mplier    <= '0;
         prod      <= '0;
         remaining <= '0;
      end else if (load) begin
         prod      <= b[0] ? a : '0;
         mcand     <= a << 1;
         mplier    <= b >> 1;
         remaining <= STEP_WIDTH'(DATA_WIDTH - 1);
      end else if (step) begin
         if (mplier[0]) begin
            prod <= prod + mcand;
         end
         mcand     <= mcand << 1;
         mplier    <= mplier >> 1;
         remaining <= remaining - STEP_WIDTH'(1);
      end
   end

   assign product = prod;
   assign done    = (remaining == '0);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle handshaked ALU with iterative multiply and bit-serial shifts.
// Define ALU_SEQ_FAST_MUL_EN for a single-cycle combinational multiplier.
module alu_seq
   import alu_seq_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic [OPRN_WIDTH-1:0] oprn,
   input  logic [DATA_WIDTH-1:0] op1,
   input  logic [DATA_WIDTH-1:0] op2,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   state_t                state;
   logic [OPRN_WIDTH-1:0] oprn_r;
   logic [DATA_WIDTH-1:0] op1_r;
   logic [DATA_WIDTH-1:0] op2_r;
   logic [DATA_WIDTH-1:0] acc;
   logic [STEP_WIDTH-1:0] steps;
   logic [STEP_WIDTH-1:0] load_steps;
   logic [DATA_WIDTH-1:0] final_value;
   logic                  accept;

   assign accept = (state == ST_IDLE) && start;

`ifndef ALU_SEQ_FAST_MUL_EN
   logic [DATA_WIDTH-1:0] mul_product;
   logic                  mul_done;

   alu_seq_mul u_mul (
      .CLK     (CLK),
      .RST     (RST),
      .load    (accept && (oprn == OP_MUL)),
      .step    ((state == ST_EXEC) && (oprn_r == OP_MUL) && !mul_done),
      .a       (op1),
      .b       (op2),
      .product (mul_product),
      .done    (mul_done)
   );
`endif

   // Zero or out-of-range shift amounts finish in a single step
   always_comb begin
      load_steps = STEP_WIDTH'(1);
      if (((oprn == OP_SHL) || (oprn == OP_SHR)) && (op2 != '0) && (op2 < DATA_WIDTH)) begin
         load_steps = op2[STEP_WIDTH-1:0];
      end
`ifndef ALU_SEQ_FAST_MUL_EN
      if (oprn == OP_MUL) begin
         load_steps = STEP_WIDTH'(DATA_WIDTH);
      end
`endif
   end

   // acc holds the shift after steps-1 single-bit moves; the last move happens here
   always_comb begin
      final_value = '0;
      case (oprn_r)
         OP_ADD: final_value = op1_r + op2_r;
         OP_SUB: final_value = op1_r - op2_r;
`ifdef ALU_SEQ_FAST_MUL_EN
         OP_MUL: final_value = op1_r * op2_r;
`else
         OP_MUL: final_value = mul_product;
`endif
         OP_AND: final_value = op1_r & op2_r;
         OP_OR:  final_value = op1_r | op2_r;
         OP_NOR: final_value = ~(op1_r | op2_r);
         OP_SLT: final_value = {{(DATA_WIDTH-1){1'b0}}, (op1_r < op2_r)};
         OP_SHL: begin
            if (op2_r == '0)               final_value = op1_r;
            else if (op2_r >= DATA_WIDTH)  final_value = '0;
            else                           final_value = acc << 1;
         end
         OP_SHR: begin
            if (op2_r == '0)               final_value = op1_r;
            else if (op2_r >= DATA_WIDTH)  final_value = '0;
            else                           final_value = acc >> 1;
         end
         default: final_value = '0;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= ST_IDLE;
         oprn_r <= '0;
         op1_r  <= '0;
         op2_r  <= '0;
         acc    <= '0;
         steps  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  oprn_r <= oprn;
                  op1_r  <= op1;
                  op2_r  <= op2;
                  acc    <= op1;
                  steps  <= load_steps;
                  busy   <= 1'b1;
                  state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (steps == STEP_WIDTH'(1)) begin
                  result <= final_value;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  steps  <= '0;
                  state  <= ST_IDLE;
               end else begin
                  steps <= steps - STEP_WIDTH'(1);
                  if (oprn_r == OP_SHL) begin
                     acc <= acc << 1;
                  end else if (oprn_r == OP_SHR) begin
                     acc <= acc >> 1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed literal cases plus randomized
// traffic compared every cycle against a countdown/arithmetic reference model.
module tb_alu_seq;
   import alu_seq_pkg::*;

   logic                  CLK = 1'b0;
   logic                  RST = 1'b0;
   logic                  start = 1'b0;
   logic [OPRN_WIDTH-1:0] oprn = '0;
   logic [DATA_WIDTH-1:0] op1 = '0;
   logic [DATA_WIDTH-1:0] op2 = '0;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] result;

   int checks = 0;
   int errors = 0;

`ifdef ALU_SEQ_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = DATA_WIDTH;
`endif

   alu_seq dut (
      .CLK    (CLK),
      .RST    (RST),
      .start  (start),
      .oprn   (oprn),
      .op1    (op1),
      .op2    (op2),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 CLK = ~CLK;

   function automatic logic [DATA_WIDTH-1:0] ref_result(input logic [OPRN_WIDTH-1:0] o,
                                                       input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b);
      case (o)
         OP_ADD: return a + b;
         OP_SUB: return a - b;
         OP_MUL: return a * b;
         OP_AND: return a & b;
         OP_OR:  return a | b;
         OP_NOR: return ~(a | b);
         OP_SLT: return (a < b) ? 32'd1 : 32'd0;
         OP_SHL: return a << b;
         OP_SHR: return a >> b;
         default: return '0;
      endcase
   endfunction

   function automatic int ref_steps(input logic [OPRN_WIDTH-1:0] o,
                                    input logic [DATA_WIDTH-1:0] b);
      if (o == OP_MUL) return MUL_LAT;
      if ((o == OP_SHL) || (o == OP_SHR)) begin
         if ((b == 0) || (b >= DATA_WIDTH)) return 1;
         return int'(b);
      end
      return 1;
   endfunction

   // Reference: an accepted op produces its value after ref_steps edges
   logic                  m_busy;
   logic                  m_done;
   logic [DATA_WIDTH-1:0] m_result;
   logic [DATA_WIDTH-1:0] m_pending;
   int                    m_left;

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_busy    <= 1'b0;
         m_done    <= 1'b0;
         m_result  <= '0;
         m_pending <= '0;
         m_left    <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_busy) begin
            if (m_left == 1) begin
               m_busy   <= 1'b0;
               m_done   <= 1'b1;
               m_result <= m_pending;
            end
            m_left <= m_left - 1;
         end else if (start) begin
            m_pending <= ref_result(oprn, op1, op2);
            m_left    <= ref_steps(oprn, op2);
            m_busy    <= 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance to the next falling edge and compare the DUT against the model
   task automatic cycle();
      @(negedge CLK);
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("done", 32'(done), 32'(m_done));
      checkOutput("result", result, m_result);
   endtask

   task automatic applyStimulus(input string name, input logic [OPRN_WIDTH-1:0] o,
                                input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b,
                                input logic [DATA_WIDTH-1:0] exp_res, input int exp_lat);
      int lat;
      start = 1'b1;
      oprn  = o;
      op1   = a;
      op2   = b;
      cycle();
      start = 1'b0;
      oprn  = 6'($urandom);
      op1   = $urandom;
      op2   = $urandom;
      lat   = 0;
      while (!done && lat < 200) begin
         cycle();
         lat++;
      end
      checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({name, "_result"}, result, exp_res);
   endtask

   task automatic random_ops(input int n, input bit hold_start);
      int r;
      for (int i = 0; i < n; i++) begin
         start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
         r = $urandom_range(0, 11);
         oprn = (r < 9) ? 6'(r + 1) : 6'($urandom);
         op1  = $urandom;
         op2  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
         cycle();
      end
      start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((busy || m_busy) && n < 100) begin
         cycle();
         n++;
      end
      if (n >= 100) checkOutput("drain_timeout", 32'd1, 32'd0);
      cycle();
   endtask

   initial begin
      int n;
      #3 RST = 1'b1;
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", result, 32'd0);
      cycle();
      cycle();
      #2 RST = 1'b0;
      cycle();

      applyStimulus("add", OP_ADD, 32'd15, 32'd3, 32'd18, 1);
      applyStimulus("sub", OP_SUB, 32'd10, 32'd5, 32'd5, 1);
      applyStimulus("sub_wrap", OP_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
      applyStimulus("and", OP_AND, 32'd5, 32'd1, 32'd1, 1);
      applyStimulus("or", OP_OR, 32'd8, 32'd2, 32'd10, 1);
      applyStimulus("nor", OP_NOR, 32'd10, 32'd3, 32'hFFFF_FFF4, 1);
      applyStimulus("slt_false", OP_SLT, 32'd15, 32'd5, 32'd0, 1);
      applyStimulus("slt_true", OP_SLT, 32'd2, 32'd4, 32'd1, 1);
      applyStimulus("mul", OP_MUL, 32'd10, 32'd2, 32'd20, MUL_LAT);
      applyStimulus("mul_max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MUL_LAT);
      applyStimulus("shl4", OP_SHL, 32'd2, 32'd4, 32'd32, 4);
      applyStimulus("shr8", OP_SHR, 32'd5, 32'd8, 32'd0, 8);
      applyStimulus("shl0", OP_SHL, 32'd7, 32'd0, 32'd7, 1);
      applyStimulus("shl40", OP_SHL, 32'd1, 32'd40, 32'd0, 1);
      applyStimulus("shr_huge", OP_SHR, 32'h8000_0000, 32'h0000_0101, 32'd0, 1);
      applyStimulus("unknown", 6'h3F, 32'd9, 32'd9, 32'd0, 1);

      // A start pulse while busy must not disturb the running op
      start = 1'b1; oprn = OP_SHL; op1 = 32'd3; op2 = 32'd20;
      cycle();
      start = 1'b0;
      cycle();
      cycle();
      start = 1'b1; oprn = OP_ADD; op1 = 32'd1; op2 = 32'd1;
      cycle();
      start = 1'b0;
      n = 0;
      while (!done && n < 100) begin
         cycle();
         n++;
      end
      checkOutput("busy_ignore_result", result, 32'h0030_0000);
      checkOutput("busy_ignore_latency", 32'(n + 3), 32'd20);
      cycle();
      checkOutput("busy_ignore_no_extra", 32'(busy), 32'd0);

      // Reset ten cycles into a multiply
      start = 1'b1; oprn = OP_MUL; op1 = 32'd7; op2 = 32'd9;
      cycle();
      start = 1'b0;
      for (int i = 0; i < 9; i++) cycle();
      #2 RST = 1'b1;
      #1;
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_done", 32'(done), 32'd0);
      checkOutput("midreset_result", result, 32'd0);
      cycle();
      #2 RST = 1'b0;
      cycle();
      applyStimulus("after_reset", OP_ADD, 32'd1, 32'd2, 32'd3, 1);

      random_ops(400, 1'b0);
      drain();
      random_ops(300, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
